// File: rtl/mult_seg_disp.sv
// Sequential shift-add multiplier with double-dabble BCD conversion and a multiplexed 7-segment display.
// Define LZB_EN to blank leading zero digits (digit 0 is always shown).
module mult_seg_disp #(
  parameter int N        = 4,
  parameter int D        = 3,
  parameter int SCAN_DIV = 1000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p,
  output logic [6:0]     s,
  output logic [D-1:0]   an
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] BCD  = 2'd2;
  localparam logic [1:0] LOAD = 2'd3;

  localparam int CW = $clog2(2*N+1);
  localparam int SW = $clog2(SCAN_DIV);

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N-1:0] sh_q, sh_d;
  logic [4*D-1:0] bcd_q, bcd_d;
  logic [4*D-1:0] adj;
  logic [2*N-1:0] p_q, p_d;
  logic [4*D-1:0] disp_q, disp_d;
  logic           done_q, done_d;
  logic [SW-1:0]  scan_q, scan_d;
  logic [D-1:0]   an_q, an_d;
  logic [D-1:0]   lead_blank;
  logic [3:0]     sel_digit;
  logic           sel_blank;

  function automatic logic [6:0] glyph(input logic [3:0] dig);
    case (dig)
      4'd0:    glyph = 7'b1110111;
      4'd1:    glyph = 7'b0010010;
      4'd2:    glyph = 7'b1011101;
      4'd3:    glyph = 7'b1011011;
      4'd4:    glyph = 7'b0111010;
      4'd5:    glyph = 7'b1101011;
      4'd6:    glyph = 7'b1101111;
      4'd7:    glyph = 7'b1010010;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1111011;
      default: glyph = 7'b0000000;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sh_d     = sh_q;
    bcd_d    = bcd_q;
    p_d      = p_q;
    disp_d   = disp_q;
    done_d   = 1'b0;
    adj      = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = MUL;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {{N{1'b0}}, a};
          mplier_d = b;
        end
      end
      MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(N-1)) begin
          state_d = BCD;
          cnt_d   = '0;
          sh_d    = acc_d;
          bcd_d   = '0;
        end
      end
      BCD: begin
        // Add 3 to every digit >= 5 before the shift so it carries correctly into the next digit.
        for (int i = 0; i < D; i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_d = (adj << 1) | {{(4*D-1){1'b0}}, sh_q[2*N-1]};
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(2*N-1)) state_d = LOAD;
      end
      default: begin
        state_d = IDLE;
        p_d     = acc_q;
        disp_d  = bcd_q;
        done_d  = 1'b1;
      end
    endcase
  end

  always_comb begin
    scan_d = scan_q + 1'b1;
    an_d   = an_q;
    if (scan_q == SW'(SCAN_DIV-1)) begin
      scan_d = '0;
      an_d   = (an_q << 1) | (an_q >> (D-1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sh_q     <= '0;
      bcd_q    <= '0;
      p_q      <= '0;
      disp_q   <= '0;
      done_q   <= 1'b0;
      scan_q   <= '0;
      an_q     <= {{(D-1){1'b0}}, 1'b1};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sh_q     <= sh_d;
      bcd_q    <= bcd_d;
      p_q      <= p_d;
      disp_q   <= disp_d;
      done_q   <= done_d;
      scan_q   <= scan_d;
      an_q     <= an_d;
    end
  end

  // A digit is blanked when it and every digit above it are zero.
  always_comb begin
    lead_blank = '0;
`ifdef LZB_EN
    begin
      logic nz;
      nz = 1'b0;
      for (int i = D-1; i >= 0; i--) begin
        nz = nz | (disp_q[4*i +: 4] != 4'd0);
        lead_blank[i] = (i != 0) && !nz;
      end
    end
`endif
  end

  always_comb begin
    sel_digit = 4'd0;
    sel_blank = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (an_q[i]) begin
        sel_digit = disp_q[4*i +: 4];
        sel_blank = lead_blank[i];
      end
    end
  end

  assign s    = sel_blank ? 7'b0000000 : glyph(sel_digit);
  assign an   = an_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign p    = p_q;

endmodule

// File: tb/tb_mult_seg_disp.sv
// Directed self-checking bench for mult_seg_disp: a N=4/D=3 instance with a fast scan
// and an N=3/D=2 instance swept over every operand pair.
module tb_mult_seg_disp;

   localparam int N     = 4;
   localparam int D     = 3;
   localparam int SCAN  = 4;
   localparam int N2    = 3;
   localparam int D2    = 2;
   localparam int SCAN2 = 2;
`ifdef LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic busy, done;
   logic [2*N-1:0] p;
   logic [6:0] s;
   logic [D-1:0] an;

   logic start2 = 1'b0;
   logic [N2-1:0] a2 = '0;
   logic [N2-1:0] b2 = '0;
   logic busy2, done2;
   logic [2*N2-1:0] p2;
   logic [6:0] s2;
   logic [D2-1:0] an2;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [6:0] glyphTab [10] = '{7'b1110111, 7'b0010010, 7'b1011101, 7'b1011011, 7'b0111010,
                                 7'b1101011, 7'b1101111, 7'b1010010, 7'b1111111, 7'b1111011};

   mult_seg_disp #(.N(N), .D(D), .SCAN_DIV(SCAN)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .p(p), .s(s), .an(an)
   );

   mult_seg_disp #(.N(N2), .D(D2), .SCAN_DIV(SCAN2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .p(p2), .s(s2), .an(an2)
   );

   always #5 clk = ~clk;

   // Bench-side count of clock edges since the last reset edge, used to predict the scan position.
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected glyph for decimal digit idx of val, honouring leading-zero blanking when enabled.
   function automatic logic [6:0] expGlyph(input int val, input int idx);
      int p10;
      p10 = 1;
      for (int i = 0; i < idx; i++) p10 = p10 * 10;
      if (LZB && idx > 0 && val < p10) return 7'b0000000;
      return glyphTab[(val / p10) % 10];
   endfunction

   task automatic checkDisplay(input int val);
      for (int c = 0; c < D*SCAN; c++) begin
         @(negedge clk);
         checkOutput("an", 32'(an), 32'(1 << ((cyc / SCAN) % D)));
         checkOutput("seg", 32'(s), 32'(expGlyph(val, (cyc / SCAN) % D)));
      end
   endtask

   task automatic idleCheck(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         checkOutput("idle_busy", 32'(busy), 32'd0);
         checkOutput("idle_done", 32'(done), 32'd0);
      end
   endtask

   // Called at a negedge; returns at the negedge where done is first seen.
   // Operands are scrambled mid-operation and, unless start is held, a stray start is pulsed while busy.
   task automatic applyStimulus(input int ia, input int ib, input bit hold, input int prev);
      int k;
      a = N'(ia);
      b = N'(ib);
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      k = 1;
      @(negedge clk);
      while (!done && k < 40) begin
         checkOutput("busy", 32'(busy), 32'd1);
         checkOutput("seg_hold", 32'(s), 32'(expGlyph(prev, (cyc / SCAN) % D)));
         if (k == 2) begin
            a = ~N'(ia);
            b = ~N'(ib);
         end
         if (!hold && k == 4) start = 1'b1;
         if (!hold && k == 5) start = 1'b0;
         k++;
         @(negedge clk);
      end
      checkOutput("latency", 32'(k), 32'(3*N + 2));
      checkOutput("done", 32'(done), 32'd1);
      checkOutput("p", 32'(p), 32'(ia * ib));
   endtask

   initial begin
      int k;
      $display("[TB] starting");
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_p", 32'(p), 32'd0);
      checkOutput("rst_an", 32'(an), 32'd1);
      checkOutput("rst_p2", 32'(p2), 32'd0);
      rst = 1'b0;
      checkDisplay(0);

      applyStimulus(15, 15, 1'b0, 0);
      idleCheck(3);
      checkDisplay(225);

      applyStimulus(0, 7, 1'b0, 225);
      idleCheck(2);
      checkDisplay(0);

      applyStimulus(6, 7, 1'b0, 0);
      idleCheck(4);
      checkDisplay(42);

      // start held through an operation: one result, then an immediate restart.
      applyStimulus(3, 5, 1'b1, 42);
      applyStimulus(9, 9, 1'b0, 15);
      idleCheck(3);
      checkDisplay(81);

      // Reset in the middle of BCD conversion, with start asserted alongside it.
      a = 4'd9;
      b = 4'd9;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (N + 2) @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_p", 32'(p), 32'd0);
      checkOutput("abort_an", 32'(an), 32'd1);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checkOutput("abort_nodone", 32'(done), 32'd0);
      end
      checkDisplay(0);

      for (int ia = 0; ia < 8; ia++) begin
         for (int ib = 0; ib < 8; ib++) begin
            a2 = N2'(ia);
            b2 = N2'(ib);
            start2 = 1'b1;
            @(posedge clk);
            #1 start2 = 1'b0;
            k = 1;
            @(negedge clk);
            while (!done2 && k < 30) begin
               k++;
               @(negedge clk);
            end
            checkOutput("latency2", 32'(k), 32'(3*N2 + 2));
            checkOutput("p2", 32'(p2), 32'(ia * ib));
            for (int c = 0; c < D2*SCAN2; c++) begin
               @(negedge clk);
               checkOutput("an2", 32'(an2), 32'(1 << ((cyc / SCAN2) % D2)));
               checkOutput("seg2", 32'(s2), 32'(expGlyph(ia * ib, (cyc / SCAN2) % D2)));
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
